v_register_arbiter: RTL and testbench
=====================================

V_REGISTER_ARBITER -- requirements
Module: v_register_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of write requesters, 2..8.
REQ-002 SHALL have parameter W, default 16: width of the shared register.
REQ-003 SHALL have parameter INIT, default 16'hFEDC: power-up and reset value of the shared register.
REQ-004 SHALL have port C, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port R, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port REQ, input, N: per-requester write request, held until that requester's ACK.
REQ-007 SHALL have port D, input, N*W: write data; requester i occupies bits [i*W +: W], held stable with REQ.
REQ-008 SHALL have port GNT, output, N: one-hot grant; all zeros when no grant is active.
REQ-009 SHALL have port ACK, output, N: one-hot, single-cycle write-complete strobe.
REQ-010 SHALL have port BUSY, output, 1: high whenever the state is not IDLE.
REQ-011 SHALL have port Q, output, W: shared register value.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, GRANT, DONE.
REQ-013 In IDLE with REQ == 0, the FSM SHALL stay in IDLE and all outputs other than Q SHALL be zero.
REQ-014 In IDLE with REQ != 0, the FSM SHALL select a winner round-robin, searching from index PTR upward modulo N; set GNT to the one-hot winner; latch the winner index; and go to GRANT.
REQ-015 In GRANT, Q SHALL load D slice of the latched winner at the closing edge, and the FSM SHALL go to DONE.
REQ-016 The write SHALL commit even if the winner drops REQ during GRANT; in that case D is sampled as presented.
REQ-017 In DONE, ACK SHALL equal the latched one-hot winner for exactly one cycle, and GNT SHALL be zero.
REQ-018 In DONE, PTR SHALL become (winner+1) mod N, and the FSM SHALL return to IDLE.
REQ-019 Latency SHALL be as follows, with REQ sampled at edge k in IDLE:
- GNT high during cycle k..k+1;
- new Q visible from edge k+2;
- ACK high in the same cycle the new Q is first visible.
REQ-020 Throughput SHALL be at most one write per 3 cycles; back-to-back requests SHALL be served without extra idle cycles.
REQ-021 A requester that keeps REQ high in the cycle after its ACK SHALL be treated as a new request and arbitrated normally at the lower round-robin priority.
REQ-022 With all N requesting continuously, grants SHALL rotate 0,1,...,N-1,0; no requester SHALL wait more than N grants.
REQ-023 REQ changes while BUSY SHALL not affect the current transaction.
REQ-024 Q SHALL change only at the GRANT->DONE edge or on reset.
REQ-025 GNT and ACK SHALL never have more than one bit set, and SHALL never be nonzero in the same cycle.

Reset
REQ-026 On R high at a rising edge, the block SHALL set: state IDLE, PTR 0, GNT 0, ACK 0, BUSY 0, Q INIT.
REQ-027 Q SHALL also hold INIT at configuration, via an initial value, before any reset.
REQ-028 Reset SHALL take priority over all other activity.
REQ-029 A transaction interrupted by reset SHALL be abandoned: no ACK, and Q is not written.
REQ-030 The requester SHALL re-request after reset.

Structure
REQ-031 State encodings (IDLE=2'd0, GRANT=2'd1, DONE=2'd2) and the default INIT SHALL live in a shared include/package v_register_pkg.
REQ-032 Round-robin selection SHALL be a combinational sub-module v_rr_pick (inputs REQ, PTR; outputs one-hot winner and index).
REQ-033 The FSM, PTR, latched index, and Q SHALL be in v_register_arbiter; outputs GNT, ACK, and BUSY SHALL be registered.

Verification
REQ-034 Power-up with no reset -> Q = 16'hFEDC, GNT = ACK = 0.
REQ-035 Single request: REQ = 4'b0100, D2 = 16'h1234 at edge k:
- GNT = 4'b0100 during cycle k+1;
- at k+2: Q = 16'h1234 and ACK = 4'b0100 for one cycle;
- PTR = 3.
REQ-036 REQ = 4'b1111 held for 12 cycles -> ACK sequence 0001, 0010, 0100, 1000, each ACK 3 cycles apart, and Q tracks each winner's D.
REQ-037 Requester 1 drops REQ during GRANT with D1 = 16'hAAAA -> Q = 16'hAAAA and ACK = 4'b0010.
REQ-038 R asserted during GRANT (Q was 16'h5555, winner D = 16'h0F0F) -> next cycle Q = 16'hFEDC, ACK = 0, state IDLE, PTR = 0.
REQ-039 Requester 0 holds REQ continuously while requester 3 requests once -> requester 3 is ACKed no later than the second grant after its REQ rises.

Source files
------------

// File: rtl/v_register_pkg.sv
// Shared definitions for the round-robin register arbiter.
//   state_e     : FSM state encoding (IDLE=0, GRANT=1, DONE=2)
//   InitDefault : default power-up/reset value of the shared register
package v_register_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic [15:0] InitDefault = 16'hFEDC;

endpackage

// File: rtl/v_rr_pick.sv
// Combinational round-robin selector.
//   req_i     : per-requester request vector
//   ptr_i     : highest-priority index; search runs ptr_i, ptr_i+1, ... modulo N
//   win_oh_o  : one-hot winner (all zeros if no request)
//   win_idx_o : binary index of the winner (0 if no request)
module v_rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    win_oh_o,
  output logic [IdxW-1:0] win_idx_o
);

  logic        found;
  int unsigned j;

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    found     = 1'b0;
    j         = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found       = 1'b1;
        win_oh_o[j] = 1'b1;
        win_idx_o   = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/v_register_arbiter.sv
// Shared register with N round-robin arbitrated writers.
// One write takes IDLE -> GRANT -> DONE (3 cycles); Q loads at the GRANT->DONE edge,
// the ACK strobe is high for the DONE cycle.
//   C    : clock (rising edge)
//   R    : synchronous active-high reset
//   REQ  : per-requester write request, held until ACK
//   D    : write data, requester i at [i*W +: W]
//   GNT  : registered one-hot grant (GRANT cycle only)
//   ACK  : registered one-hot write-complete strobe (DONE cycle only)
//   BUSY : registered, high while the FSM is not IDLE
//   Q    : shared register value
module v_register_arbiter
  import v_register_pkg::*;
#(
  parameter int unsigned    N    = 4,
  parameter int unsigned    W    = 16,
  parameter logic [W-1:0]   INIT = W'(InitDefault)
) (
  input  logic           C,
  input  logic           R,
  input  logic [N-1:0]   REQ,
  input  logic [N*W-1:0] D,
  output logic [N-1:0]   GNT,
  output logic [N-1:0]   ACK,
  output logic           BUSY,
  output logic [W-1:0]   Q
);

  localparam int unsigned IdxW = $clog2(N);

  // Declaration initialisers give a defined state at configuration, before any reset.
  state_e          state_q = StIdle;
  state_e          state_d;
  logic [IdxW-1:0] ptr_q   = '0;
  logic [IdxW-1:0] ptr_d;
  logic [IdxW-1:0] idx_q   = '0;
  logic [IdxW-1:0] idx_d;
  logic [W-1:0]    q_q     = INIT;
  logic [W-1:0]    q_d;
  logic [N-1:0]    gnt_q   = '0;
  logic [N-1:0]    gnt_d;
  logic [N-1:0]    ack_q   = '0;
  logic [N-1:0]    ack_d;
  logic            busy_q  = 1'b0;
  logic            busy_d;

  logic [N-1:0]    pick_oh;
  logic [IdxW-1:0] pick_idx;

  v_rr_pick #(
    .N    (N),
    .IdxW (IdxW)
  ) u_pick (
    .req_i     (REQ),
    .ptr_i     (ptr_q),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    q_d     = q_q;
    gnt_d   = '0;
    ack_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (|REQ) begin
          gnt_d   = pick_oh;
          idx_d   = pick_idx;
          state_d = StGrant;
        end
      end
      StGrant: begin
        // Commit regardless of whether the winner still holds REQ.
        q_d     = D[idx_q*W +: W];
        ack_d   = gnt_q;
        state_d = StDone;
      end
      StDone: begin
        ptr_d   = (idx_q == IdxW'(N - 1)) ? '0 : idx_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      q_q     <= INIT;
      gnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      q_q     <= q_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT  = gnt_q;
  assign ACK  = ack_q;
  assign BUSY = busy_q;
  assign Q    = q_q;

endmodule

// File: tb/tb_v_register_arbiter.sv
module tb_v_register_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           C;
  logic           R;
  logic [N-1:0]   REQ;
  logic [N*W-1:0] D;
  logic [N-1:0]   GNT;
  logic [N-1:0]   ACK;
  logic           BUSY;
  logic [W-1:0]   Q;

  v_register_arbiter #(
    .N    (N),
    .W    (W),
    .INIT (16'hFEDC)
  ) dut (
    .C    (C),
    .R    (R),
    .REQ  (REQ),
    .D    (D),
    .GNT  (GNT),
    .ACK  (ACK),
    .BUSY (BUSY),
    .Q    (Q)
  );

  typedef struct packed {
    logic [N-1:0] ack;
    logic [W-1:0] q;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_ack_cyc = 0;
  bit   mon_en  = 0;
  bit   gap_en  = 0;
  bit   gap_seen = 0;

  initial C = 1'b0;
  always #5 C = ~C;
  always @(posedge C) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every ACK strobe.
  always @(negedge C) begin
    if (mon_en) begin
      chk("gnt_ack_exclusive", 32'((GNT != 0) && (ACK != 0)), 32'd0);
      if (ACK != 0) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'(ACK), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack", 32'(ACK), 32'(e.ack));
          chk("q_at_ack", 32'(Q), 32'(e.q));
        end
        if (gap_en) begin
          if (gap_seen) chk("ack_spacing", 32'(cyc - last_ack_cyc), 32'd3);
          gap_seen = 1;
        end
        last_ack_cyc = cyc;
      end
    end
  end

  task automatic set_d(input int i, input logic [W-1:0] v);
    D[i*W +: W] = v;
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  // One isolated transaction; starts and ends in IDLE.
  task automatic one_txn(input string name, input logic [N-1:0] req,
                         input logic [N-1:0] exp_oh, input logic [W-1:0] exp_q);
    REQ = req;
    sb.push_back('{ack: exp_oh, q: exp_q});
    step();
    chk({name, "_gnt"}, 32'(GNT), 32'(exp_oh));
    chk({name, "_busy"}, 32'(BUSY), 32'd1);
    step();
    REQ = '0;
    step();
    chk({name, "_idle_ack"}, 32'(ACK), 32'd0);
    chk({name, "_idle_busy"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    R   = 1'b0;
    REQ = '0;
    D   = '0;
    #1;
    // Power-up, no reset applied.
    chk("pwr_q", 32'(Q), 32'hFEDC);
    chk("pwr_gnt", 32'(GNT), 32'd0);
    chk("pwr_ack", 32'(ACK), 32'd0);
    chk("pwr_busy", 32'(BUSY), 32'd0);
    mon_en = 1;

    // Single request from requester 2; PTR becomes 3.
    set_d(0, 16'hA0A0); set_d(1, 16'hB1B1); set_d(2, 16'h1234); set_d(3, 16'hD3D3);
    one_txn("single", 4'b0100, 4'b0100, 16'h1234);

    // PTR == 3: requesters 0 and 3 compete, 3 wins; PTR wraps to 0.
    one_txn("ptr3", 4'b1001, 4'b1000, 16'hD3D3);

    // All four requesting for 12 cycles: rotation 0,1,2,3, ACKs 3 cycles apart.
    set_d(2, 16'hC2C2);
    sb.push_back('{ack: 4'b0001, q: 16'hA0A0});
    sb.push_back('{ack: 4'b0010, q: 16'hB1B1});
    sb.push_back('{ack: 4'b0100, q: 16'hC2C2});
    sb.push_back('{ack: 4'b1000, q: 16'hD3D3});
    gap_seen = 0;
    gap_en   = 1;
    REQ = 4'b1111;
    repeat (12) step();
    REQ = '0;
    step();
    gap_en = 0;
    chk("rot_drained", 32'(sb.size()), 32'd0);
    chk("rot_idle", 32'(BUSY), 32'd0);

    // Requester 1 drops REQ during GRANT; the write still commits.
    set_d(1, 16'hAAAA);
    REQ = 4'b0010;
    sb.push_back('{ack: 4'b0010, q: 16'hAAAA});
    step();
    chk("drop_gnt", 32'(GNT), 32'b0010);
    REQ = '0;
    step();
    step();

    // Reset during GRANT abandons the write (Q was 5555, winner D = 0F0F).
    set_d(2, 16'h5555);
    one_txn("pre_rst", 4'b0100, 4'b0100, 16'h5555);
    set_d(0, 16'h0F0F);
    REQ = 4'b0001;
    step();
    chk("rst_gnt", 32'(GNT), 32'b0001);
    R   = 1'b1;
    REQ = '0;
    step();
    R = 1'b0;
    chk("rst_q", 32'(Q), 32'hFEDC);
    chk("rst_ack", 32'(ACK), 32'd0);
    chk("rst_gnt_clr", 32'(GNT), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    step();
    chk("rst_q_held", 32'(Q), 32'hFEDC);
    // PTR back at 0 (it was 3 before reset).
    one_txn("rst_ptr0", 4'b1111, 4'b0001, 16'h0F0F);

    // Requester 0 holds REQ; requester 3 requests once and must be next.
    REQ = 4'b0001;
    sb.push_back('{ack: 4'b0001, q: 16'h0F0F});
    sb.push_back('{ack: 4'b1000, q: 16'hD3D3});
    sb.push_back('{ack: 4'b0001, q: 16'h0F0F});
    step();
    chk("fair_gnt0", 32'(GNT), 32'b0001);
    REQ = 4'b1001;
    step();
    step();
    step();
    chk("fair_gnt3", 32'(GNT), 32'b1000);
    step();
    REQ = 4'b0001;
    step();
    step();
    chk("fair_gnt0_again", 32'(GNT), 32'b0001);
    step();
    REQ = '0;
    repeat (4) step();
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
